reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 18 +
 rtl/reg_write_arbiter_wr_reg.sv | 21 ++
 rtl/reg_write_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the two-requester register write arbiter.
// Holds the FSM state encoding, requester indices and counter sizing helper.
package reg_write_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam logic REQ_IDX0 = 1'b0;
   localparam logic REQ_IDX1 = 1'b1;

   // Hold counter must represent HOLD_CYCLES; never narrower than one bit.
   function automatic int cnt_width(input int hold);
      return (hold < 1) ? 1 : $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/reg_write_arbiter_wr_reg.sv
// Shared WIDTH-bit register with write enable and async active-low clear.
// The clock is free-running; the enable selects between hold and load.
module wr_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter for a single shared register, with a
// programmable busy window after every committed write.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             REQ0,
   input  logic [WIDTH-1:0] D0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] D1,
   output logic [WIDTH-1:0] O,
   output logic             ACK0,
   output logic             ACK1,
   output logic             BUSY,
   output logic             LAST
);

   localparam int            CW        = cnt_width(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

   state_e          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            elig0, elig1;
   logic            win, win_idx;
   logic [WIDTH-1:0] wr_data;

   // State register
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == ST_IDLE) begin
         if (win && (HOLD_CYCLES > 0)) begin
            state_nx = ST_HOLD;
            cnt_nx   = HOLD_LOAD;
         end
      end else begin
         cnt_nx = cnt - 1'b1;
         if (cnt <= CW'(1)) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      end
   end

   // Arbitration: a requester just acked is ignored for one cycle, which
   // is what lets a held REQ alternate cleanly when HOLD_CYCLES is 0.
   always_comb begin
      elig0   = (state == ST_IDLE) && REQ0 && !ACK0;
      elig1   = (state == ST_IDLE) && REQ1 && !ACK1;
      win     = elig0 || elig1;
      win_idx = (elig0 && elig1) ? ~LAST : (elig1 ? REQ_IDX1 : REQ_IDX0);
      wr_data = (win_idx == REQ_IDX1) ? D1 : D0;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         BUSY <= 1'b0;
         LAST <= REQ_IDX1;
      end else begin
         ACK0 <= win && (win_idx == REQ_IDX0);
         ACK1 <= win && (win_idx == REQ_IDX1);
         BUSY <= (state_nx == ST_HOLD);
         if (win) LAST <= win_idx;
      end
   end

   wr_reg #(.WIDTH(WIDTH)) u_wr_reg (
      .clk   (CLK),
      .rst_n (RESETN),
      .we    (win),
      .d     (wr_data),
      .q     (O)
   );

   ack_onehot: assert property (@(posedge CLK) disable iff (!RESETN) !(ACK0 && ACK1));

endmodule
